// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_pkg
//  Purpose  : Shared ISA definitions for the instruction encoder/loader:
//             type encoding, func codes, word field positions and the
//             type/func legality check used by encoder and decoder tests.
//  Revision : 1.0  initial release
// ============================================================================
package instr_pkg;

  typedef enum logic [1:0] {
    TYPE_MEM  = 2'b00,
    TYPE_DATA = 2'b01,
    TYPE_CTRL = 2'b10,
    TYPE_RSVD = 2'b11
  } instr_type_e;

  // Memory-type func codes
  localparam logic [4:0] c_func_load  = 5'b00000;
  localparam logic [4:0] c_func_store = 5'b01000;

  // Control-type funcs must have these low bits clear
  localparam logic [2:0] c_ctrl_func_low = 3'b000;

  // Data funcs with this bit clear are register-form (rd, rs1, rs2);
  // with it set they are immediate-form (rd, rs1, imm)
  localparam int c_data_imm_bit = 4;

  // Field positions inside the 32-bit instruction word
  localparam int c_type_msb = 31;
  localparam int c_type_lsb = 30;
  localparam int c_func_msb = 29;
  localparam int c_func_lsb = 25;
  localparam int c_f1_msb   = 24;
  localparam int c_f1_lsb   = 21;
  localparam int c_f2_msb   = 20;
  localparam int c_f2_lsb   = 17;
  localparam int c_f3_msb   = 16;
  localparam int c_f3_lsb   = 13;
  localparam int c_imm_msb  = 16;
  localparam int c_imm_lsb  = 0;

  // True when the type/func pair appears in the ISA decode table
  function automatic logic is_legal(input logic [1:0] typ, input logic [4:0] func);
    logic ok;
    ok = 1'b0;
    case (instr_type_e'(typ))
      TYPE_MEM:  ok = (func == c_func_load) || (func == c_func_store);
      TYPE_DATA: begin
        case (func)
          5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011,
          5'b10100, 5'b10101, 5'b10110, 5'b10111,
          5'b11000, 5'b11001, 5'b11010, 5'b11100: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      TYPE_CTRL: ok = (func[2:0] == c_ctrl_func_low);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fifo
//  Purpose  : Small synchronous FIFO holding encoded words between the
//             field-accept stage and the IMEM write port. Head word is
//             visible combinationally; clr empties it in one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [c_ptr_w:0]   wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[c_ptr_w] != rd_ptr_q[c_ptr_w]) &&
                     (wr_ptr_q[c_ptr_w-1:0] == rd_ptr_q[c_ptr_w-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q[c_ptr_w-1:0]];

  // Pointer advance; clear discards all stored entries
  always_comb begin
    wr_ptr_d = wr_ptr_q + (c_ptr_w+1)'(w_do_push);
    rd_ptr_d = rd_ptr_q + (c_ptr_w+1)'(w_do_pop);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q[c_ptr_w-1:0]] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder_loader
//  Purpose  : Accepts instruction field bundles, drops illegal type/func
//             pairs, packs legal ones into 32-bit words and streams them
//             through a FIFO into sequential IMEM addresses.
//  Revision : 1.0  initial release
// ============================================================================
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [4:0]        in_func,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [16:0]       in_imm,
  input  logic              in_last,
  input  logic              imem_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              w_fifo_full, w_fifo_empty, w_fifo_clr;
  logic [31:0]       w_fifo_head;
  logic [31:0]       w_word;
  logic              w_in_ready, w_accept, w_legal, w_push, w_pop, w_at_end;
  instr_type_e       w_type;

  assign w_type     = instr_type_e'(in_type);
  assign w_legal    = is_legal(in_type, in_func);
  assign w_in_ready = (state_q == S_RUN) && !w_fifo_full && !ovf_q;
  assign w_accept   = in_valid && w_in_ready;
  assign w_push     = w_accept && w_legal;
  // The write in flight uses the final address: nothing more may be popped
  assign w_at_end   = we_q && (addr_q == c_last_addr);
  assign w_pop      = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !w_fifo_empty &&
                      !imem_busy && !ovf_q && !w_at_end;
  // A new session starts with an empty FIFO (entries stranded by overflow)
  assign w_fifo_clr = (state_q == S_IDLE) && start;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_fifo_clr),
    .push  (w_push),
    .wdata (w_word),
    .pop   (w_pop),
    .rdata (w_fifo_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Pack the incoming fields into the instruction word layout
  always_comb begin
    w_word = '0;
    w_word[c_type_msb:c_type_lsb] = in_type;
    w_word[c_func_msb:c_func_lsb] = in_func;
    case (w_type)
      TYPE_CTRL: begin
        w_word[c_f1_msb:c_f1_lsb]   = in_rs1;
        w_word[c_f2_msb:c_f2_lsb]   = in_rs2;
        w_word[c_imm_msb:c_imm_lsb] = in_imm;
      end
      TYPE_DATA: begin
        w_word[c_f1_msb:c_f1_lsb] = in_rd;
        w_word[c_f2_msb:c_f2_lsb] = in_rs1;
        if (in_func[c_data_imm_bit]) begin
          w_word[c_imm_msb:c_imm_lsb] = in_imm;
        end else begin
          w_word[c_f3_msb:c_f3_lsb] = in_rs2;
        end
      end
      default: begin
        w_word[c_f1_msb:c_f1_lsb]   = in_rd;
        w_word[c_f2_msb:c_f2_lsb]   = in_rs1;
        w_word[c_imm_msb:c_imm_lsb] = in_imm;
      end
    endcase
  end

  // Session FSM, write-port staging and address/word bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    we_d    = w_pop;
    wdata_d = w_pop ? w_fifo_head : wdata_q;

    // Account for the write presented this cycle; the address saturates
    if (we_q) begin
      words_d = words_q + (ADDR_W+1)'(1);
      if (addr_q == c_last_addr) begin
        ovf_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    if (w_accept && !w_legal) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          words_d = '0;
          addr_d  = c_base_addr;
        end
      end
      S_RUN: begin
        if (ovf_q || (w_accept && in_last)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((w_fifo_empty || ovf_q) && !we_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= c_base_addr;
      words_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Reset suppresses a staged write in the same cycle it is asserted
  assign imem_we    = we_q && !rst;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign words      = words_q;
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign ovf        = ovf_q;
  assign in_ready   = w_in_ready;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder_loader
//  Purpose  : Self-checking bench for instr_encoder_loader (ADDR_W=3 so the
//             address-overflow corner is reachable in a short run).
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder_loader;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int TMO    = 100;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_type;
  logic [4:0]        in_func;
  logic [3:0]        in_rd, in_rs1, in_rs2;
  logic [16:0]       in_imm;
  logic              in_last;
  logic              imem_busy;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words;
  logic              done, err, ovf;

  instr_encoder_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_func    (in_func),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_busy  (imem_busy),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .words      (words),
    .done       (done),
    .err        (err),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          exp_addr  = 0;
  int          sess_words = 0;
  bit          exp_err   = 0;
  bit          rand_run  = 0;

  typedef struct {
    int          t, f, rd, rs1, rs2, imm;
    bit          legal;
    logic [31:0] word;
  } vec_t;
  vec_t tab[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference legality straight from the ISA table
  function automatic bit ref_legal(input int t, input int f);
    case (t)
      0:       return (f == 0) || (f == 8);
      1:       return f inside {0, 1, 2, 3, 11, 20, 21, 22, 23, 24, 25, 26, 28};
      2:       return (f % 8) == 0;
      default: return 0;
    endcase
  endfunction

  // Reference packing with plain arithmetic on field weights
  function automatic logic [31:0] ref_encode(input longint t, input longint f, input longint rd,
                                             input longint rs1, input longint rs2, input longint imm);
    longint w;
    w = t * 64'h4000_0000 + f * 64'h0200_0000;
    if (t == 2)                w = w + rs1 * 64'h20_0000 + rs2 * 64'h2_0000 + imm;
    else if (t == 1 && f < 16) w = w + rd * 64'h20_0000 + rs1 * 64'h2_0000 + rs2 * 64'h2000;
    else                       w = w + rd * 64'h20_0000 + rs1 * 64'h2_0000 + imm;
    return 32'(w);
  endfunction

  // Every IMEM write must match the next expected word at the next address
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wdata", imem_wdata, mon_exp);
        check("waddr", {29'b0, imem_addr}, exp_addr);
        exp_addr++;
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    exp_addr   = 0;
    sess_words = 0;
    exp_err    = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int t, input int f, input int rd, input int rs1, input int rs2,
                      input int imm, input bit last, input bit legal, input logic [31:0] word);
    int waited;
    @(negedge clk);
    in_type  = 2'(t);
    in_func  = 5'(f);
    in_rd    = 4'(rd);
    in_rs1   = 4'(rs1);
    in_rs2   = 4'(rs2);
    in_imm   = 17'(imm);
    in_last  = last;
    in_valid = 1'b1;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: in_ready 0 for %0d cycles, expected 1", TMO);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk);
    if (legal) begin
      exp_q.push_back(word);
      sess_words++;
    end else begin
      exp_err = 1;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_rand(input bit last, input bit force_legal);
    int t, f;
    int dfun[13] = '{0, 1, 2, 3, 11, 20, 21, 22, 23, 24, 25, 26, 28};
    int rd, rs1, rs2, imm;
    if (force_legal || $urandom_range(0, 3) != 0) begin
      t = $urandom_range(0, 2);
      if (t == 0)      f = $urandom_range(0, 1) * 8;
      else if (t == 1) f = dfun[$urandom_range(0, 12)];
      else             f = $urandom_range(0, 3) * 8;
    end else begin
      t = $urandom_range(0, 3);
      f = $urandom_range(0, 31);
    end
    rd  = $urandom_range(0, 15);
    rs1 = $urandom_range(0, 15);
    rs2 = $urandom_range(0, 15);
    imm = $urandom_range(0, 131071);
    send(t, f, rd, rs1, rs2, imm, last, ref_legal(t, f), ref_encode(t, f, rd, rs1, rs2, imm));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done 0 after %0d cycles, expected 1", name, TMO);
    end
    check({name, "_words"}, 32'(words), sess_words);
    check({name, "_err"}, {31'b0, err}, {31'b0, exp_err});
    check({name, "_ovf"}, {31'b0, ovf}, (sess_words >= 8) ? 32'd1 : 32'd0);
    check({name, "_pending"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'b0, done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_type = '0; in_func = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0; imem_busy = 1'b0;

    tab[0]  = '{1,  0,  1, 2, 3, 0,       1, 32'h4024_6000};
    tab[1]  = '{1,  4,  1, 2, 3, 0,       0, 32'h0};
    tab[2]  = '{0,  0,  4, 5, 0, 8,       1, 32'h008A_0008};
    tab[3]  = '{2,  24, 9, 2, 3, 'h1FFFC, 1, 32'hB047_FFFC};
    tab[4]  = '{0,  8,  7, 1, 6, 'h12345, 1, 32'h10E3_2345};
    tab[5]  = '{1,  20, 15, 15, 0, 'h1FFFF, 1, 32'h69FF_FFFF};
    tab[6]  = '{3,  0,  1, 1, 1, 1,       0, 32'h0};
    tab[7]  = '{2,  1,  1, 1, 1, 1,       0, 32'h0};
    tab[8]  = '{0,  1,  1, 1, 1, 1,       0, 32'h0};
    tab[9]  = '{1,  11, 3, 4, 5, 'h1FFFF, 1, 32'h5668_A000};
    tab[10] = '{1,  28, 0, 0, 0, 1,       1, 32'h7800_0001};
    tab[11] = '{1,  27, 2, 2, 2, 2,       0, 32'h0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_imem_we", {31'b0, imem_we}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_ovf", {31'b0, ovf}, 0);
    check("rst_words", 32'(words), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", imem_wdata, 0);
    rst = 1'b0;

    // Two-bundle session with a start pulse during RUN that must be ignored
    do_start();
    send(1, 0, 1, 2, 3, 0, 0, 1, 32'h4024_6000);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send(0, 0, 4, 5, 0, 8, 1, 1, 32'h008A_0008);
    wait_done("basic");

    // Encoding table incl. illegal pairs mid-stream and an illegal last
    do_start();
    for (int i = 0; i < 12; i++) begin
      send(tab[i].t, tab[i].f, tab[i].rd, tab[i].rs1, tab[i].rs2, tab[i].imm,
           (i == 11), tab[i].legal, tab[i].word);
    end
    wait_done("table");

    // IMEM busy for 5 cycles while 6 bundles are offered
    do_start();
    fork
      begin
        imem_busy = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_in_ready_full", {31'b0, in_ready}, 0);
        check("busy_no_we", {31'b0, imem_we}, 0);
        check("busy_addr_held", 32'(imem_addr), 0);
        imem_busy = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) send_rand(i == 5, 1);
      end
    join
    wait_done("busy");

    // Reset with words queued in the FIFO
    do_start();
    send_rand(0, 1);
    send_rand(0, 1);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < TMO) begin @(negedge clk); cnt++; end
    imem_busy = 1'b1;
    for (int i = 0; i < 3; i++) send_rand(0, 1);
    @(negedge clk);
    check("midrst_words_before", 32'(words), 2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_we", {31'b0, imem_we}, 0);
    check("midrst_words", 32'(words), 0);
    check("midrst_in_ready", {31'b0, in_ready}, 0);
    check("midrst_addr", 32'(imem_addr), 0);
    rst = 1'b0;
    exp_q.delete();
    imem_busy = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_idle", {31'b0, in_ready}, 0);
    do_start();
    send_rand(1, 1);
    wait_done("after_rst");

    // Address overflow: 8 writes fill the space, no wrap, later bundle refused
    do_start();
    for (int i = 0; i < 8; i++) send_rand(0, 1);
    wait_done("ovf");
    check("ovf_addr_no_wrap", 32'(imem_addr), 7);
    @(negedge clk);
    in_type = 2'b01; in_func = 5'b00000; in_valid = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (in_ready === 1'b1) cnt++;
    end
    in_valid = 1'b0;
    check("ovf_9th_refused", cnt, 0);

    // Randomised sessions with random IMEM back-pressure
    rand_run = 1;
    fork
      begin
        for (int s = 0; s < 15; s++) begin
          int n;
          n = $urandom_range(1, 7);
          do_start();
          for (int i = 0; i < n; i++) send_rand(i == n - 1, 0);
          wait_done("rand");
        end
        rand_run = 0;
      end
      begin
        while (rand_run) begin
          @(negedge clk);
          imem_busy = ($urandom_range(0, 3) == 0);
        end
        imem_busy = 1'b0;
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
